// File: rtl/iter_divider.sv
// iter_divider: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Restoring radix-2 division, one quotient bit per cycle, valid/ready result handshake.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, next;
  logic [1:0] op;
  logic neg_q, neg_r;
  logic [WIDTH-1:0] quo, dvs, res, a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] rem, rem_sh;
  logic [CW-1:0] cnt;
  logic sgn, a_neg, b_neg, div0, ovf, accept, last, ge;
  assign sgn = ~md_op[0];
  assign a_neg = sgn & src_a[WIDTH-1];
  assign b_neg = sgn & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;
  assign div0 = src_b == '0;
  assign ovf = sgn && src_a == {1'b1, {(WIDTH-1){1'b0}}} && src_b == '1;
  assign accept = start & ready & ~flush;
  assign last = cnt == CW'(WIDTH - 1);
  // the extra remainder bit keeps the shifted value from wrapping before the compare
  assign rem_sh = (rem << 1) | (WIDTH+1)'(quo[WIDTH-1]);
  assign ge = rem_sh >= {1'b0, dvs};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  assign result = res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    ready = state == IDLE;
    busy = state == BUSY || state == FIX;
    result_valid = state == DONE;
    case (state)
      IDLE: next = accept ? (div0 || ovf ? DONE : BUSY) : IDLE;
      BUSY: next = flush ? IDLE : (last ? FIX : BUSY);
      FIX:  next = flush ? IDLE : DONE;
      DONE: next = flush || result_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quo <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      res <= '0;
    end else if (accept) begin
      op <= md_op;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      quo <= a_mag;
      dvs <= b_mag;
      rem <= '0;
      cnt <= '0;
      if (div0) res <= md_op[1] ? src_a : '1;
      else if (ovf) res <= md_op[1] ? '0 : src_a;
    end else if (state == BUSY) begin
      rem <= ge ? rem_sh - {1'b0, dvs} : rem_sh;
      quo <= {quo[WIDTH-2:0], ge};
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      res <= op[1] ? r_fix : q_fix;
    end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: randomized and directed checks of iter_divider against an arithmetic reference model.
module tb_iter_divider;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  logic clk = 0, rst_n = 0, start = 0, flush = 0, result_ready = 0;
  logic [1:0] md_op = 0;
  logic [W-1:0] src_a = 0, src_b = 0;
  logic ready, result_valid, busy;
  logic [W-1:0] result;
  int vectors = 0, miscompares = 0;

  iter_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return op[1] ? a : '1;
    if (!op[0] && a == MIN && b == '1) return op[1] ? '0 : a;
    case (op)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return MIN;
      4: return $urandom_range(0, 20);
      5: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] exp;
    bit sp;
    int n;
    exp = model(op, a, b);
    sp = (b == 0) || (!op[0] && a == MIN && b == '1);
    md_op = op; src_a = a; src_b = b; start = 1;
    @(posedge clk); #1;
    start = 0; src_a = $urandom; src_b = $urandom; md_op = 2'($urandom);
    chk({tag, "_acc"}, {ready, busy}, sp ? 2'b00 : 2'b01);
    n = 1;
    while (!result_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, n, sp ? 1 : W + 2);
    chk({tag, "_res"}, result, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {ready, result_valid, result}, {2'b01, exp});
    end
    result_ready = 1;
    @(posedge clk); #1;
    result_ready = 0;
    chk({tag, "_idle"}, {ready, result_valid, busy}, 3'b100);
  endtask

  initial begin
    bit seen;
    #2;
    chk("rst_state", {ready, result_valid, busy, result}, {3'b100, 32'd0});
    #10 rst_n = 1;
    @(posedge clk); #1;
    run_op("div20_3", 2'd0, 32'd20, 32'd3, 0);
    run_op("rem20_3", 2'd2, 32'd20, 32'd3, 0);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("divu_5_0", 2'd1, 32'd5, 32'd0, 0);
    run_op("rem_x_0", 2'd2, 32'h8000_0001, 32'd0, 0);
    run_op("div_ovf", 2'd0, MIN, '1, 0);
    run_op("rem_ovf", 2'd2, MIN, '1, 0);
    run_op("divu_min_m1", 2'd1, MIN, '1, 0);
    run_op("bp", 2'd0, 32'd20, 32'd3, 10);
    run_op("b2b", 2'd3, 32'd1000, 32'd7, 0);
    // a flush in IDLE must block an accept on that edge
    start = 1; flush = 1; md_op = 0; src_a = 32'd9; src_b = 32'd2;
    @(posedge clk); #1;
    start = 0; flush = 0;
    chk("idle_flush", {ready, result_valid, busy}, 3'b100);
    md_op = 0; src_a = 32'd12345; src_b = 32'd11; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_idle", {ready, result_valid, busy}, 3'b100);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= result_valid;
    end
    chk("flush_noval", seen, 0);
    md_op = 2'd1; src_a = 32'd99999; src_b = 32'd13; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1 chk("rst_mid", {ready, result_valid, busy, result}, {3'b100, 32'd0});
    #1 rst_n = 1;
    run_op("div100_7", 2'd0, 32'd100, 32'd7, 0);
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] a, b;
      a = pick(); b = pick();
      run_op("rand", 2'($urandom), a, b, $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
